// File: rtl/cpld_pkg.sv
// Shared types and default decode addresses for the CPLD address tracker.
// Optional feature macro: SHADOW_REG_EN (enables shadow RAM select register).
package cpld_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [15:0] ROM_SEL_ADR_DEF    = 16'hFE30;
  localparam logic [15:0] SHADOW_SEL_ADR_DEF = 16'hFE34;
  localparam logic [11:0] WIN_BASE_DEF       = 12'hFE4;

  // Without the shadow register, its decode and state are tied off to zero.
`ifdef SHADOW_REG_EN
  localparam bit SHADOW_ON = 1'b1;
`else
  localparam bit SHADOW_ON = 1'b0;
`endif

endpackage

// File: rtl/cpld_adr_match.sv
// Registered address comparator producing the ROM, shadow and I/O window decode flags.
// Shadow flag is held at zero unless SHADOW_REG_EN is defined.
module cpld_adr_match
  import cpld_pkg::*;
#(
  parameter int unsigned           ADR_W          = 16,
  parameter logic [ADR_W-1:0]      ROM_SEL_ADR    = ADR_W'(ROM_SEL_ADR_DEF),
  parameter logic [ADR_W-1:0]      SHADOW_SEL_ADR = ADR_W'(SHADOW_SEL_ADR_DEF),
  parameter logic [ADR_W-5:0]      WIN_BASE       = (ADR_W-4)'(WIN_BASE_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ADR_W-1:0] adr,
  output logic             dec_rom_reg,
  output logic             dec_shadow_reg,
  output logic             dec_win
);

  // Flags only change when a new bus cycle latches its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_rom_reg    <= 1'b0;
      dec_shadow_reg <= 1'b0;
      dec_win        <= 1'b0;
    end else if (load) begin
      dec_rom_reg    <= (adr == ROM_SEL_ADR);
      dec_shadow_reg <= SHADOW_ON && (adr == SHADOW_SEL_ADR);
      dec_win        <= (adr[ADR_W-1:4] == WIN_BASE);
    end
  end

endmodule

// File: rtl/cpld_adr_tracker.sv
// Tracks CPU bus cycles, latches the BBC address and shadows the paged ROM / shadow RAM registers.
// Optional feature macro: SHADOW_REG_EN (shadow RAM select register).
module cpld_adr_tracker
  import cpld_pkg::*;
#(
  parameter int unsigned      ADR_W          = 16,
  parameter int unsigned      LAT_W          = 12,
  parameter logic [ADR_W-1:0] ROM_SEL_ADR    = ADR_W'(ROM_SEL_ADR_DEF),
  parameter logic [ADR_W-1:0] SHADOW_SEL_ADR = ADR_W'(SHADOW_SEL_ADR_DEF),
  parameter logic [ADR_W-5:0] WIN_BASE       = (ADR_W-4)'(WIN_BASE_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [7:0]       cpu_data,
  input  logic             cpu_vda,
  input  logic             cpu_rnw,
  input  logic             cpu_dv,
  output logic [LAT_W-1:0] bbc_adr,
  output logic             dec_rom_reg,
  output logic             dec_shadow_reg,
  output logic             dec_win,
  output logic [3:0]       rom_bank,
  output logic             shadow_en,
  output logic             wr_strobe,
  output logic             busy
);

  state_t state;
  logic   rnw_q;
  logic   load_c;
  logic   unused_data_c;

  assign load_c        = (state == IDLE) && cpu_vda;
  assign unused_data_c = ^cpu_data[6:4];

  cpld_adr_match #(
    .ADR_W         (ADR_W),
    .ROM_SEL_ADR   (ROM_SEL_ADR),
    .SHADOW_SEL_ADR(SHADOW_SEL_ADR),
    .WIN_BASE      (WIN_BASE)
  ) u_match (
    .clk           (clk),
    .rst           (rst),
    .load          (load_c),
    .adr           (cpu_adr),
    .dec_rom_reg   (dec_rom_reg),
    .dec_shadow_reg(dec_shadow_reg),
    .dec_win       (dec_win)
  );

  // Register writes commit on the ADDR->DATA edge so wr_strobe covers the DATA cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bbc_adr   <= '0;
      rnw_q     <= 1'b1;
      rom_bank  <= 4'h0;
      shadow_en <= 1'b0;
      wr_strobe <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_vda) begin
            state   <= ADDR;
            bbc_adr <= cpu_adr[LAT_W-1:0];
            rnw_q   <= cpu_rnw;
            busy    <= 1'b1;
          end
        end
        ADDR: begin
          if (cpu_dv) begin
            state <= DATA;
            if (!rnw_q && dec_rom_reg) begin
              rom_bank <= cpu_data[3:0];
            end
            if (!rnw_q && SHADOW_ON && dec_shadow_reg) begin
              shadow_en <= cpu_data[7];
            end
            wr_strobe <= !rnw_q && (dec_rom_reg || dec_shadow_reg);
          end
        end
        DATA: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpld_adr_tracker.md
CPLD_ADR_TRACKER -- requirements
Module: cpld_adr_tracker

Interface
REQ-001 Parameter ADR_W, default 16, CPU address width.
REQ-002 Parameter LAT_W, default 12, width of the latched BBC address (LAT_W <= ADR_W).
REQ-003 Parameter ROM_SEL_ADR, default 16'hFE30, paged ROM select register address.
REQ-004 Parameter SHADOW_SEL_ADR, default 16'hFE34, shadow RAM select register address.
REQ-005 Parameter WIN_BASE, default 12'hFE4, match value for cpu_adr[ADR_W-1:4] (I/O window).
REQ-006 Port: clk  in  1  single system clock; all state updates on its rising edge.
REQ-007 Port: rst  in  1  synchronous, active-high reset.
REQ-008 Port: cpu_adr  in  ADR_W  CPU address.
REQ-009 Port: cpu_data  in  8  CPU write data.
REQ-010 Port: cpu_vda  in  1  address-valid strobe, starts a bus cycle.
REQ-011 Port: cpu_rnw  in  1  1 = read, 0 = write; sampled with cpu_vda.
REQ-012 Port: cpu_dv  in  1  data-valid strobe, ends a bus cycle.
REQ-013 Port: bbc_adr  out  LAT_W  registered cpu_adr[LAT_W-1:0].
REQ-014 Port: dec_rom_reg, dec_shadow_reg, dec_win  out  1 each  registered decode flags.
REQ-015 Port: rom_bank  out  4  shadow copy of the paged ROM register.
REQ-016 Port: shadow_en  out  1  shadow RAM select (bit 7 of last SHADOW_SEL_ADR write).
REQ-017 Port: wr_strobe  out  1  one-cycle pulse when a decoded register write is committed.
REQ-018 Port: busy  out  1  high while a bus cycle is open.

Function
REQ-019 FSM states IDLE, ADDR, DATA; reset state IDLE.
REQ-020 IDLE: cpu_vda=1 -> ADDR; bbc_adr, dec flags and captured rnw load from cpu_adr/cpu_rnw on that edge (latency 1 cycle).
REQ-021 ADDR: cpu_dv=1 -> DATA; else stay; cpu_vda in ADDR ignored, latched address held.
REQ-022 DATA: unconditional -> IDLE after one cycle; if captured write and dec_rom_reg, rom_bank <= cpu_data[3:0] sampled at ADDR->DATA edge; if captured write and dec_shadow_reg, shadow_en <= cpu_data[7].
REQ-023 wr_strobe high for exactly the DATA cycle of a write to ROM_SEL_ADR or SHADOW_SEL_ADR; never on reads or other addresses.
REQ-024 Decode: dec_rom_reg = (adr==ROM_SEL_ADR); dec_shadow_reg = (adr==SHADOW_SEL_ADR); dec_win = (adr[ADR_W-1:4]==WIN_BASE); full-width equality, no partial decode.
REQ-025 Decode flags held until the next IDLE->ADDR transition; not cleared on return to IDLE.
REQ-026 busy = 1 in ADDR and DATA, 0 in IDLE.
REQ-027 cpu_vda and cpu_dv both high in IDLE: only the address is taken; cpu_dv ignored, FSM -> ADDR.
REQ-028 cpu_vda high in DATA: ignored; a new cycle starts only from IDLE.
REQ-029 Back-to-back cycles: minimum 3 clocks per cycle; no cycle is lost provided cpu_vda is held until IDLE.

Reset
REQ-030 rst=1 at any clock edge, including mid-cycle: state IDLE, bbc_adr 0, all dec flags 0, rom_bank 0, shadow_en 0, wr_strobe 0, busy 0.
REQ-031 A write in progress when rst asserts is abandoned; no register update.

Configuration
REQ-032 Macro SHADOW_REG_EN: defined -> shadow decode and shadow_en behave per REQ-022/024.
REQ-033 Without SHADOW_REG_EN: dec_shadow_reg and shadow_en constant 0; SHADOW_SEL_ADR writes produce no wr_strobe.

Structure
REQ-034 Shared package cpld_pkg: FSM state type, default ROM_SEL_ADR/SHADOW_SEL_ADR/WIN_BASE constants.
REQ-035 One sub-module cpld_adr_match: parametrised registered comparator producing the three decode flags.

Verification
REQ-036 rst then write FE30 data 8'h0B -> rom_bank 4'hB, wr_strobe one pulse in DATA, bbc_adr 12'hE30.
REQ-037 Read FE30 -> rom_bank unchanged, wr_strobe 0, dec_rom_reg 1.
REQ-038 Write FE34 data 8'h80 with SHADOW_REG_EN -> shadow_en 1; without -> shadow_en 0, no wr_strobe.
REQ-039 Access FE47 -> dec_win 1; access FE50 -> dec_win 0; access FE3F -> all flags 0.
REQ-040 rst asserted in ADDR of write FE30 data 8'h05 -> rom_bank 0, state IDLE, no wr_strobe.
REQ-041 cpu_vda and cpu_dv together in IDLE, then cpu_dv next cycle -> single cycle of 3 clocks, busy high exactly 2 cycles.
